// File: rtl/ex_muldiv_signed.sv
// rtl/ex_muldiv_signed.sv - iterative signed/unsigned multiply/divide unit
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/MOD return 0 with Z,V set.
module ex_muldiv_signed #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 5
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_valid,
    output logic              ow_ready,
    input  logic [1:0]        iw_op,
    input  logic              iw_sgn_en,
    input  logic [DATA_W-1:0] iw_a,
    input  logic [DATA_W-1:0] iw_b,
    input  logic              iw_flush,
    output logic              ow_done,
    output logic [DATA_W-1:0] ow_result,
    output logic [3:0]        ow_flags
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          op;
    logic                sgn;
    logic                neg_res;
    logic [DATA_W-1:0]   opb;
    logic [2*DATA_W-1:0] prod;
`ifdef MULDIV_DIV_EN
    logic                neg_rem;
    logic                div0;
    logic                ovf;
    logic [DATA_W:0]     div_trial;
`endif

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] prod_s;
    logic                mul_hi_nz;
    logic [DATA_W-1:0]   fix_res;
    logic                fix_c, fix_v;

    assign a_neg = iw_sgn_en & iw_a[DATA_W-1];
    assign b_neg = iw_sgn_en & iw_b[DATA_W-1];
    assign a_mag = a_neg ? -iw_a : iw_a;
    assign b_mag = b_neg ? -iw_b : iw_b;

    // Multiply: prod = {accumulator, remaining multiplier bits}, shifted right each step
    assign mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opb} : {(DATA_W+1){1'b0}});
`ifdef MULDIV_DIV_EN
    // Divide: prod = {partial remainder, dividend/quotient bits}, shifted left each step
    assign div_trial = prod[2*DATA_W-1:DATA_W-1] - {1'b0, opb};
`endif

    assign prod_s    = neg_res ? -prod : prod;
    assign mul_hi_nz = |prod[2*DATA_W-1:DATA_W];

    always_comb begin
        fix_res = '0;
        fix_c   = 1'b0;
        fix_v   = 1'b0;
        case (op)
            2'b00: begin
                fix_res = prod_s[DATA_W-1:0];
                fix_c   = mul_hi_nz;
                fix_v   = mul_hi_nz | (sgn & (neg_res ? (prod[DATA_W-1:0] > MIN_VAL) : prod[DATA_W-1]));
            end
            2'b01: begin
                fix_res = prod_s[2*DATA_W-1:DATA_W];
                fix_c   = mul_hi_nz;
            end
`ifdef MULDIV_DIV_EN
            2'b10: begin
                fix_res = div0 ? '1 : (neg_res ? -prod[DATA_W-1:0] : prod[DATA_W-1:0]);
                fix_v   = div0 | ovf;
            end
            default: begin
                fix_res = neg_rem ? -prod[2*DATA_W-1:DATA_W] : prod[2*DATA_W-1:DATA_W];
                fix_v   = div0 | ovf;
            end
`else
            default: fix_v = 1'b1;
`endif
        endcase
    end

    assign ow_ready = (state == S_IDLE);
    assign ow_done  = (state == S_DONE);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            sgn       <= 1'b0;
            neg_res   <= 1'b0;
            opb       <= '0;
            prod      <= '0;
            ow_result <= '0;
            ow_flags  <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem   <= 1'b0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else if (iw_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (iw_valid) begin
                    op      <= iw_op;
                    sgn     <= iw_sgn_en;
                    neg_res <= a_neg ^ b_neg;
                    cnt     <= '0;
                    opb     <= iw_op[1] ? b_mag : a_mag;
                    prod    <= {{DATA_W{1'b0}}, (iw_op[1] ? a_mag : b_mag)};
`ifdef MULDIV_DIV_EN
                    neg_rem <= a_neg;
                    div0    <= (iw_b == '0);
                    ovf     <= iw_sgn_en & (iw_a == MIN_VAL) & (&iw_b);
                    state   <= S_RUN;
`else
                    // No divider: DIV/MOD take a one-cycle bypass through FIX
                    state   <= iw_op[1] ? S_FIX : S_RUN;
`endif
                end
                S_RUN: begin
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_EN
                        if (op[1])
                            prod <= div_trial[DATA_W] ? {prod[2*DATA_W-2:0], 1'b0}
                                                      : {div_trial[DATA_W-1:0], prod[DATA_W-2:0], 1'b1};
                        else
`endif
                        prod <= {mul_sum, prod[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    ow_result <= fix_res;
                    ow_flags  <= {fix_v, fix_c, fix_res[DATA_W-1], (fix_res == '0)};
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_signed.sv
// tb/tb_ex_muldiv_signed.sv - randomized self-checking bench for ex_muldiv_signed
module tb_ex_muldiv_signed;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, flush, sgn_en;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] last_res;
    logic [3:0]   last_flg;

    always #5 clk = ~clk;

    ex_muldiv_signed #(.DATA_W(W), .CNT_W(5)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(valid), .ow_ready(ready),
        .iw_op(op), .iw_sgn_en(sgn_en), .iw_a(a), .iw_b(b), .iw_flush(flush),
        .ow_done(done), .ow_result(result), .ow_flags(flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] m_op, input logic m_sgn,
                                  input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                  output logic [W-1:0] res, output logic [3:0] flg, output int lat);
        longint sa, sb, ma, mb, p;
        longint minv, maxv, umax;
        logic [63:0] pv;
        logic c, v;
        minv = -(longint'(1) << (W-1));
        maxv = (longint'(1) << (W-1)) - 1;
        umax = (longint'(1) << W) - 1;
        sa = m_sgn ? longint'($signed(m_a)) : longint'(m_a);
        sb = m_sgn ? longint'($signed(m_b)) : longint'(m_b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        c = 1'b0;
        v = 1'b0;
        lat = W + 2;
        res = '0;
        if (!m_op[1]) begin
            p  = sa * sb;
            pv = p;
            res = m_op[0] ? pv[2*W-1:W] : pv[W-1:0];
            c  = ((ma * mb) >> W) != 0;
            if (!m_op[0]) v = m_sgn ? (p < minv || p > maxv) : (p > umax);
        end else begin
`ifdef MULDIV_DIV_EN
            if (m_b == '0) begin
                res = m_op[0] ? m_a : '1;
                v = 1'b1;
            end else if (m_sgn && sa == minv && sb == -1) begin
                res = m_op[0] ? '0 : m_a;
                v = 1'b1;
            end else begin
                pv = m_op[0] ? (sa % sb) : (sa / sb);
                res = pv[W-1:0];
            end
`else
            res = '0;
            v = 1'b1;
            lat = 1;
`endif
        end
        flg = {v, c, res[W-1], (res == '0)};
    endfunction

    task automatic launch(input logic [1:0] l_op, input logic l_sgn, input logic [W-1:0] l_a, input logic [W-1:0] l_b);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", 64'(ready), 64'(1));
        valid = 1'b1; op = l_op; sgn_en = l_sgn; a = l_a; b = l_b;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] t_op, input logic t_sgn,
                         input logic [W-1:0] t_a, input logic [W-1:0] t_b);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int lat, n;
        model(t_op, t_sgn, t_a, t_b, er, ef, lat);
        launch(t_op, t_sgn, t_a, t_b);
        check($sformatf("%s.busy", tag), 64'(ready), 64'(0));
        // scramble inputs and keep strobing while busy; all of it must be ignored
        valid = (lat > 4);
        op = 2'($urandom); sgn_en = 1'($urandom); a = W'($urandom); b = W'($urandom);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) valid = 1'b0;
        end
        valid = 1'b0;
        check($sformatf("%s.lat", tag), 64'(n), 64'(lat));
        check($sformatf("%s.res", tag), 64'(result), 64'(er));
        check($sformatf("%s.flags", tag), 64'(flags), 64'(ef));
        last_res = er;
        last_flg = ef;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return {1'b1, {(W-1){1'b0}}};
            2: return '1;
            3: return W'(1);
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [1:0]   op;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t dir[14];
    logic seen;

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; sgn_en = 1'b0; op = '0; a = '0; b = '0;
        last_res = '0; last_flg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.result", 64'(result), 64'(0));
        check("rst.flags", 64'(flags), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst.ready", 64'(ready), 64'(1));

        dir[0]  = '{2'b00, 1'b1, 24'h7FFFFF, 24'h000002};
        dir[1]  = '{2'b00, 1'b1, 24'hFFFFFD, 24'h000005};
        dir[2]  = '{2'b01, 1'b1, 24'hFFFFFD, 24'h000005};
        dir[3]  = '{2'b10, 1'b1, 24'hFFFFF9, 24'h000002};
        dir[4]  = '{2'b11, 1'b1, 24'hFFFFF9, 24'h000002};
        dir[5]  = '{2'b10, 1'b0, 24'h000007, 24'h000002};
        dir[6]  = '{2'b11, 1'b0, 24'h000007, 24'h000002};
        dir[7]  = '{2'b10, 1'b1, 24'h800000, 24'hFFFFFF};
        dir[8]  = '{2'b11, 1'b1, 24'h800000, 24'hFFFFFF};
        dir[9]  = '{2'b10, 1'b0, 24'h000010, 24'h000000};
        dir[10] = '{2'b11, 1'b0, 24'h000010, 24'h000000};
        dir[11] = '{2'b11, 1'b1, 24'hFFFFF0, 24'h000000};
        dir[12] = '{2'b00, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
        dir[13] = '{2'b01, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
        foreach (dir[i]) do_op($sformatf("dir%0d", i), dir[i].op, dir[i].sgn, dir[i].a, dir[i].b);

        for (int i = 0; i < 40; i++)
            do_op($sformatf("rnd%0d", i), 2'($urandom), 1'($urandom), rand_operand(), rand_operand());

        // flush during RUN cycle 10
        launch(2'b00, 1'b1, 24'h123456, 24'h000777);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.ready", 64'(ready), 64'(1));
        check("flush.result_held", 64'(result), 64'(last_res));
        check("flush.flags_held", 64'(flags), 64'(last_flg));
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1 seen |= done; end
        check("flush.no_done", 64'(seen), 64'(0));
        do_op("after_flush", 2'b00, 1'b1, 24'hFFFFFD, 24'h000005);

        // flush and valid together in IDLE: no accept
        @(negedge clk);
        valid = 1'b1; flush = 1'b1; op = 2'b00; a = 24'h000003; b = 24'h000004;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        check("flush_valid.ready", 64'(ready), 64'(1));
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1 seen |= done; end
        check("flush_valid.no_done", 64'(seen), 64'(0));
        check("flush_valid.result_held", 64'(result), 64'(last_res));

        // reset in the middle of RUN
        launch(2'b01, 1'b1, 24'h654321, 24'hABCDEF);
        repeat (8) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst.result", 64'(result), 64'(0));
        check("midrst.flags", 64'(flags), 64'(0));
        check("midrst.done", 64'(done), 64'(0));
        check("midrst.ready", 64'(ready), 64'(1));
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1 seen |= done; end
        check("midrst.no_done", 64'(seen), 64'(0));
        do_op("after_rst", 2'b10, 1'b1, 24'hFFFFF9, 24'h000002);
        do_op("after_rst2", 2'b00, 1'b0, 24'h000007, 24'h000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
